// File: rtl/mcu32x.sv
// mcu32x: single-cycle, non-pipelined 32-bit micro core with an internal instruction ROM,
// a 16 x 32 register file (r0 hard-wired to zero) and a small internal data RAM.
// Every clock one instruction is fetched at the PC and executed; its outputs are
// registered and become visible one cycle after execution.
//
// Optional feature: define MCU32X_MUL_EN to enable opcode C as MUL (low 32 bits of
// rs1 * rs2). Without the macro opcode C behaves like any other undefined opcode.
//
// Parameters:
//   ROM_DEPTH  - number of 32-bit instruction ROM words (PC is 4 bits)
//   DMEM_DEPTH - number of 32-bit data RAM words (indexed by address[3:0])
//   ROM_IMAGE  - ROM contents, word 0 in the least significant 32 bits
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous, active-low reset
//   result    out  value produced by the last executed instruction
//   address   out  LW/SW effective word address, otherwise PC of the executed instruction
//   mem_read  out  high for the cycle following an executed LW
//   mem_write out  high for the cycle following an executed SW
module mcu32x #(
   parameter int unsigned               ROM_DEPTH  = 16,
   parameter int unsigned               DMEM_DEPTH = 16,
   parameter logic [ROM_DEPTH*32-1:0]   ROM_IMAGE  = {
      {6{32'h0000_0000}},  // 15..10 NOP
      32'hF000_0000,       // 9  HALT
      32'h6700_00FF,       // 8  ADDI r7,r0,0xFF
      32'hA053_0001,       // 7  BEQ  r5,r3,+1
      32'h5651_0000,       // 6  XOR  r6,r5,r1
      32'h8500_0004,       // 5  LW   r5,[r0+4]
      32'h9003_0004,       // 4  SW   r3,[r0+4]
      32'h2412_0000,       // 3  SUB  r4,r1,r2
      32'h1312_0000,       // 2  ADD  r3,r1,r2
      32'h6200_0003,       // 1  ADDI r2,r0,3
      32'h6100_0005        // 0  ADDI r1,r0,5
   }
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] result,
   output logic [31:0] address,
   output logic        mem_read,
   output logic        mem_write
);

   typedef enum logic [3:0] {
      OpNop  = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpAnd = 4'h3,
      OpOr   = 4'h4, OpXor = 4'h5, OpAddi = 4'h6, OpLui = 4'h7,
      OpLw   = 4'h8, OpSw  = 4'h9, OpBeq = 4'hA, OpJmp = 4'hB,
      OpMul  = 4'hC, OpHalt = 4'hF
   } opcode_e;

   logic [3:0]  pc_q, pc_d;
   logic        halted_q, halted_d;
   logic [31:0] result_q, result_d;
   logic [31:0] address_q, address_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] rf_q [16];
   logic [31:0] dmem_q [DMEM_DEPTH];

   logic [31:0] instr;
   opcode_e     op;
   logic [3:0]  rd, rs1, rs2;
   logic [15:0] imm16;
   logic [31:0] rs1_val, rs2_val, simm, eff_addr;
   logic [3:0]  pc_inc;
   logic        rf_we, dm_we;
   logic [31:0] rf_wdata;

   // Words beyond ROM_DEPTH read as NOP.
   always_comb begin
      instr = '0;
      if ({28'b0, pc_q} < ROM_DEPTH) begin
         instr = ROM_IMAGE[32*pc_q +: 32];
      end
   end

   assign op       = opcode_e'(instr[31:28]);
   assign rd       = instr[27:24];
   assign rs1      = instr[23:20];
   assign rs2      = instr[19:16];
   assign imm16    = instr[15:0];
   assign rs1_val  = rf_q[rs1];
   assign rs2_val  = rf_q[rs2];
   assign simm     = {{16{imm16[15]}}, imm16};
   assign eff_addr = rs1_val + simm;
   assign pc_inc   = pc_q + 4'd1;

   always_comb begin
      pc_d        = pc_inc;
      halted_d    = halted_q;
      result_d    = '0;
      address_d   = {28'b0, pc_q};
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      rf_we       = 1'b0;
      rf_wdata    = '0;
      dm_we       = 1'b0;
      if (halted_q) begin
         pc_d      = pc_q;
         result_d  = result_q;
         address_d = address_q;
      end else begin
         case (op)
            OpAdd:  begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
            OpSub:  begin rf_we = 1'b1; rf_wdata = rs1_val - rs2_val; end
            OpAnd:  begin rf_we = 1'b1; rf_wdata = rs1_val & rs2_val; end
            OpOr:   begin rf_we = 1'b1; rf_wdata = rs1_val | rs2_val; end
            OpXor:  begin rf_we = 1'b1; rf_wdata = rs1_val ^ rs2_val; end
            OpAddi: begin rf_we = 1'b1; rf_wdata = rs1_val + simm; end
            OpLui:  begin rf_we = 1'b1; rf_wdata = {imm16, 16'h0000}; end
`ifdef MCU32X_MUL_EN
            OpMul:  begin rf_we = 1'b1; rf_wdata = rs1_val * rs2_val; end
`endif
            OpLw: begin
               rf_we      = 1'b1;
               rf_wdata   = dmem_q[eff_addr[3:0]];
               address_d  = eff_addr;
               mem_read_d = 1'b1;
            end
            OpSw: begin
               dm_we       = 1'b1;
               result_d    = rs2_val;
               address_d   = eff_addr;
               mem_write_d = 1'b1;
            end
            OpBeq: begin
               if (rs1_val == rs2_val) pc_d = pc_inc + imm16[3:0];
               result_d = {28'b0, pc_d};
            end
            OpJmp: begin
               pc_d     = imm16[3:0];
               result_d = {28'b0, pc_d};
            end
            OpHalt: begin
               // HALT reports its own PC but keeps the previous result.
               pc_d     = pc_q;
               halted_d = 1'b1;
               result_d = result_q;
            end
            default: ;
         endcase
         if (rf_we) result_d = rf_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q        <= '0;
         halted_q    <= 1'b0;
         result_q    <= '0;
         address_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
         for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem_q[i] <= '0;
      end else begin
         pc_q        <= pc_d;
         halted_q    <= halted_d;
         result_q    <= result_d;
         address_q   <= address_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         if (rf_we && rd != 4'd0) rf_q[rd] <= rf_wdata;
         if (dm_we) dmem_q[eff_addr[3:0]] <= rs2_val;
      end
   end

   assign result    = result_q;
   assign address   = address_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mcu32x.sv
// Self-checking bench for mcu32x: the default-program core and a second core loaded with a
// small arithmetic program run side by side. Expected outputs are queued before each clock
// edge and compared after it.
module tb_mcu32x;

   logic        clk;
   logic        reset;
   logic [31:0] result0, address0, result1, address1;
   logic        mem_read0, mem_write0, mem_read1, mem_write1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   localparam logic [511:0] ArithRom = {
      {12{32'h0000_0000}},
      32'hF000_0000,   // 3 HALT
      32'hC311_0000,   // 2 MUL  r3,r1,r1
      32'h1211_0000,   // 1 ADD  r2,r1,r1
      32'h6100_FFFF    // 0 ADDI r1,r0,-1
   };

`ifdef MCU32X_MUL_EN
   localparam logic [31:0] MulRes = 32'h0000_0001;
`else
   localparam logic [31:0] MulRes = 32'h0000_0000;
`endif

   mcu32x dut0 (
      .clk       (clk),
      .reset     (reset),
      .result    (result0),
      .address   (address0),
      .mem_read  (mem_read0),
      .mem_write (mem_write0)
   );

   mcu32x #(.ROM_IMAGE(ArithRom)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .result    (result1),
      .address   (address1),
      .mem_read  (mem_read1),
      .mem_write (mem_write1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        which;
      logic [31:0] res;
      logic [31:0] addr;
      logic        mr;
      logic        mw;
   } exp_t;

   exp_t sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic which, input logic [31:0] res, input logic [31:0] addr,
                           input logic mr, input logic mw);
      exp_t e;
      e.which = which;
      e.res   = res;
      e.addr  = addr;
      e.mr    = mr;
      e.mw    = mw;
      sb_q.push_back(e);
   endtask

   // Advance one clock, then compare every queued expectation against its core.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.which == 1'b0) begin
            check_eq($sformatf("c%0d d0 result", cyc), result0, e.res);
            check_eq($sformatf("c%0d d0 address", cyc), address0, e.addr);
            check_eq($sformatf("c%0d d0 mem_read", cyc), {31'b0, mem_read0}, {31'b0, e.mr});
            check_eq($sformatf("c%0d d0 mem_write", cyc), {31'b0, mem_write0}, {31'b0, e.mw});
         end else begin
            check_eq($sformatf("c%0d d1 result", cyc), result1, e.res);
            check_eq($sformatf("c%0d d1 address", cyc), address1, e.addr);
            check_eq($sformatf("c%0d d1 mem_read", cyc), {31'b0, mem_read1}, {31'b0, e.mr});
            check_eq($sformatf("c%0d d1 mem_write", cyc), {31'b0, mem_write1}, {31'b0, e.mw});
         end
      end
   endtask

   // Expected default-program trace, one entry per executed instruction.
   logic [31:0] def_res  [9] = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd8, 32'd8, 32'hD, 32'd9, 32'd9};
   logic [31:0] def_addr [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 32'd6, 32'd7, 32'd9};
   logic        def_mr   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic        def_mw   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [31:0] ar_res   [4];
   logic [31:0] ar_addr  [4] = '{32'd0, 32'd1, 32'd2, 32'd3};

   initial begin
      ar_res[0] = 32'hFFFF_FFFF;
      ar_res[1] = 32'hFFFF_FFFE;
      ar_res[2] = MulRes;
      ar_res[3] = MulRes;  // HALT keeps the previous result

      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push_exp(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         push_exp(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
         step();
      end

      // Full default program plus the arithmetic program in parallel.
      reset = 1'b1;
      for (int c = 0; c < 9; c++) begin
         push_exp(1'b0, def_res[c], def_addr[c], def_mr[c], def_mw[c]);
         push_exp(1'b1, ar_res[c < 4 ? c : 3], ar_addr[c < 4 ? c : 3], 1'b0, 1'b0);
         step();
      end
      check_eq("r7 untouched", dut0.rf_q[7], 32'd0);
      check_eq("ram4 after sw", dut0.dmem_q[4], 32'd8);
      check_eq("r6 xor", dut0.rf_q[6], 32'hD);

      // Halted: outputs hold.
      for (int c = 0; c < 20; c++) begin
         push_exp(1'b0, 32'd9, 32'd9, 1'b0, 1'b0);
         step();
      end
      check_eq("ram4 held while halted", dut0.dmem_q[4], 32'd8);

      // Reset while halted, then restart from word 0.
      reset = 1'b0;
      push_exp(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      step();
      check_eq("ram4 cleared", dut0.dmem_q[4], 32'd0);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         push_exp(1'b0, def_res[c], def_addr[c], 1'b0, 1'b0);
         step();
      end

      // Reset on the SW edge: store is aborted.
      reset = 1'b0;
      push_exp(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      step();
      check_eq("ram4 after aborted sw", dut0.dmem_q[4], 32'd0);
      check_eq("r3 cleared", dut0.rf_q[3], 32'd0);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         push_exp(1'b0, def_res[c], def_addr[c], 1'b0, 1'b0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mcu32x.md
MCU32X -- requirements
Module: mcu32x

Interface
REQ-001 Parameter ROM_DEPTH, default 16, number of 32-bit instruction ROM words; the program counter (PC) is 4 bits wide.
REQ-002 Parameter DMEM_DEPTH, default 16, number of 32-bit data RAM words, indexed by address[3:0].
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 result  output  32  registered value produced by the last executed instruction.
REQ-006 address  output  32  registered memory word address (LW/SW) or the PC of the executed instruction (all other opcodes).
REQ-007 mem_read  output  1  registered; high for exactly the cycle following an executed LW.
REQ-008 mem_write  output  1  registered; high for exactly the cycle following an executed SW.

Function
REQ-009 The core SHALL be single-cycle and non-pipelined: one instruction is fetched from the internal ROM and executed per clock, and its outputs are visible one cycle after execution.
REQ-010 Instruction format: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16; register file of 16 x 32-bit registers, r0 reads 0 and ignores writes.
REQ-011 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDI (rs1 + sign-extended imm16), 7 LUI (imm16 << 16), 8 LW, 9 SW, A BEQ, B JMP, F HALT; 32-bit arithmetic wraps modulo 2^32 with no flags.
REQ-012 ALU ops write rd and drive result = written value.
REQ-013 LW/SW effective address = rs1 + sign-extended imm16; LW writes rd from data RAM and drives result = loaded data; SW writes rs2 to data RAM and drives result = rs2.
REQ-014 BEQ: if rs1 == rs2, next PC = PC + 1 + imm16[3:0], else PC + 1; result = next PC (zero-extended); JMP: next PC = imm16[3:0], result = next PC.
REQ-015 The PC SHALL wrap from 15 to 0, and branch/jump targets SHALL use modulo-16 arithmetic.
REQ-016 HALT stops the PC; while halted, result and address hold their values, mem_read and mem_write are 0, and registers and RAM are unchanged until reset.
REQ-017 NOP and undefined opcodes SHALL drive result = 0 and write no state.
REQ-018 An LW of the same address written by an immediately preceding SW returns the new data.
REQ-019 The ROM default program SHALL be, by word: 0 ADDI r1,r0,5; 1 ADDI r2,r0,3; 2 ADD r3,r1,r2; 3 SUB r4,r1,r2; 4 SW r3,[r0+4]; 5 LW r5,[r0+4]; 6 XOR r6,r5,r1; 7 BEQ r5,r3,+1; 8 ADDI r7,r0,0xFF; 9 HALT; 10-15 NOP.

Reset
REQ-020 While reset == 0 at a rising clk edge, the core SHALL clear PC, the halted flag, all registers and all data RAM to 0, and SHALL drive result = 0, address = 0, mem_read = 0 and mem_write = 0.
REQ-021 Asserting reset mid-program (including while halted) SHALL abort the current instruction with no register or RAM write, and execution SHALL restart at word 0 on the first edge with reset == 1.

Configuration
REQ-022 With MCU32X_MUL_EN defined, opcode C is MUL: rd = low 32 bits of rs1 * rs2, result = product; without the macro, opcode C behaves as an undefined opcode (REQ-017).

Verification
REQ-023 Release reset, run 3 cycles -> result sequence 5, 3, 8 with address 0, 1, 2 and mem_read/mem_write 0.
REQ-024 Continue execution -> word 3 yields result 2; word 4 yields address 4, mem_write 1, result 8; word 5 yields address 4, mem_read 1, result 8.
REQ-025 Continue execution -> word 6 yields result 0x0000000D; BEQ is taken with result 9 and address 7; word 8 never executes, so r7 remains 0.
REQ-026 After HALT executes at word 9 -> the outputs hold for 20+ cycles with mem_read and mem_write 0.
REQ-027 Hold reset low during the SW cycle -> RAM word 4 reads 0 and the outputs are all 0; after release, the sequence of REQ-023 repeats.
REQ-028 Load a ROM with ADDI r1,r0,-1 then ADD r2,r1,r1 -> result 0xFFFFFFFF, then 0xFFFFFFFE; with MCU32X_MUL_EN, MUL r3,r1,r1 -> result 1.
